vfpu_op_sched: RTL and testbench
================================

VFPU_OP_SCHED -- requirements
Module: vfpu_op_sched

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width (single-precision).
REQ-002 Parameter INS_W, default 6, VFPU instruction encoding width.
REQ-003 Parameter DEPTH, default 4, request FIFO depth; power of 2, >= 2.
REQ-004 Parameter TIMEOUT, default 64, max WAIT cycles for a core result; >= 2.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 op_vld  input  1  request valid from test driver.
REQ-008 op_rdy  output  1  FIFO can accept; equals !full, combinational from occupancy.
REQ-009 vfpu_ins  input  INS_W  instruction of request.
REQ-010 operand_a / operand_b / operand_c  input  DATA_W each  request operands.
REQ-011 core_vld  output  1  one-cycle issue strobe to VFPU core.
REQ-012 core_ins  output  INS_W  issued instruction, registered, stable from ISSUE through DONE.
REQ-013 core_a / core_b / core_c  output  DATA_W each  issued operands, registered, stable from ISSUE through DONE.
REQ-014 res_rdy  input  1  core result strobe.
REQ-015 res  input  DATA_W  core result, valid when res_rdy=1.
REQ-016 out_vld  output  1  result available to monitor.
REQ-017 out_rdy  input  1  monitor accepts result.
REQ-018 out_res  output  DATA_W  captured result.
REQ-019 out_ins  output  INS_W  instruction echo of completed op.
REQ-020 out_err  output  1  1 = op timed out, out_res forced 0.
REQ-021 occupancy  output  clog2(DEPTH)+1  FIFO entry count.
REQ-022 stray  output  1  sticky flag: res_rdy seen outside WAIT.

Function
REQ-023 FIFO push when op_vld && op_rdy; entry = {vfpu_ins, a, b, c}; order strictly FIFO.
REQ-024 Pointers wrap modulo DEPTH; full when occupancy==DEPTH; empty when occupancy==0.
REQ-025 When full, op_rdy=0 and op_vld is ignored; a pop in the same cycle raises op_rdy in the next cycle, not the current one.
REQ-026 Simultaneous push and pop when not full and not empty leave occupancy unchanged.
REQ-027 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-028 IDLE: if FIFO not empty, pop head into core_* registers and go to ISSUE; otherwise stay in IDLE.
REQ-029 ISSUE: core_vld=1 for exactly this cycle; clear the timer to 0; go to WAIT.
REQ-030 WAIT: on res_rdy=1, capture res into out_res, set out_err=0, and go to DONE.
REQ-031 WAIT, no res_rdy: the timer increments; if the timer==TIMEOUT-1, set out_res=0 and out_err=1 and go to DONE.
REQ-032 res_rdy in the same cycle as the timeout condition: the result wins (out_err=0).
REQ-033 DONE: out_vld=1, out_ins=core_ins; if out_rdy=1 go to IDLE, otherwise hold out_vld and out_res/out_ins/out_err stable.
REQ-034 res_rdy in IDLE, ISSUE, or DONE sets stray=1, which holds until reset; res is discarded and state is unaffected.
REQ-035 Latency: request accepted on edge N into an empty FIFO while IDLE -> core_vld high in cycle N+2.
REQ-036 Latency: res_rdy in cycle M -> out_vld high in cycle M+1.
REQ-037 Back-to-back: the earliest next core_vld is 2 cycles after the out_vld/out_rdy handshake (DONE->IDLE->ISSUE).
REQ-038 Only one op outstanding at the core at any time; incoming requests continue to fill the FIFO meanwhile.
REQ-039 core_vld, out_vld, op_rdy, and occupancy are glitch-free functions of registered state.

Reset
REQ-040 Asserting rst_n=0 at any time, including mid-WAIT or DONE, immediately forces: state IDLE, FIFO empty, pointers 0, timer 0, stray 0.
REQ-041 Reset values: op_rdy=1, core_vld=0, out_vld=0, out_err=0, occupancy=0, and core_*/out_res/out_ins all 0.
REQ-042 A result pending at reset is lost; res_rdy arriving after reset release while IDLE sets stray.

Verification
REQ-043 Single op: push ins=6'h01, a=32'h3F800000, b=32'h40000000, c=0. Then res_rdy with res=32'h40400000 three cycles after core_vld -> out_vld with out_res=32'h40400000, out_ins=6'h01, out_err=0.
REQ-044 Fill: push 5 ops with the core never responding (DEPTH=4). After the first pop, 4 entries are held and occupancy=4 with op_rdy=0. The 6th op is refused until the first op times out.
REQ-045 Timeout: TIMEOUT=64 with no res_rdy -> out_vld occurs exactly 64 cycles after core_vld+1, with out_err=1 and out_res=0. res_rdy on the last WAIT cycle instead -> out_err=0.
REQ-046 Backpressure: hold out_rdy=0 for 10 cycles in DONE. Outputs stay stable, no second core_vld occurs, and the FIFO still accepts pushes.
REQ-047 Stray/reset: res_rdy while IDLE -> stray=1. Asserting rst_n=0 during WAIT with occupancy=3 -> all outputs go to reset values without waiting for a clock edge.
REQ-048 Ordering: push 4 ops with ins 6'h01..6'h04, with randomised core latency 1..20 -> out_ins sequence is 01, 02, 03, 04.

Source files
------------

// File: rtl/vfpu_op_sched.sv
// rtl/vfpu_op_sched.sv - request FIFO plus single-outstanding issue/wait/done scheduler for a VFPU core
module vfpu_op_sched #(
  parameter int DATA_W  = 32,
  parameter int INS_W   = 6,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_vld,
  output logic                     op_rdy,
  input  logic [INS_W-1:0]         vfpu_ins,
  input  logic [DATA_W-1:0]        operand_a,
  input  logic [DATA_W-1:0]        operand_b,
  input  logic [DATA_W-1:0]        operand_c,
  output logic                     core_vld,
  output logic [INS_W-1:0]         core_ins,
  output logic [DATA_W-1:0]        core_a,
  output logic [DATA_W-1:0]        core_b,
  output logic [DATA_W-1:0]        core_c,
  input  logic                     res_rdy,
  input  logic [DATA_W-1:0]        res,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [DATA_W-1:0]        out_res,
  output logic [INS_W-1:0]         out_ins,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     stray
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = INS_W + 3 * DATA_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic          push, pop, timeout_hit, finish;

  assign op_rdy      = (count != CW'(DEPTH));
  assign occupancy   = count;
  assign push        = op_vld && op_rdy;
  assign pop         = (state == IDLE) && (count != '0);
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign finish      = (state == WAIT) && (res_rdy || timeout_hit);

  always_comb begin
    state_nxt = state;
    core_vld  = 1'b0;
    out_vld   = 1'b0;
    case (state)
      IDLE:  if (pop) state_nxt = ISSUE;
      ISSUE: begin
        core_vld  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (finish) state_nxt = DONE;
      DONE:  begin
        out_vld = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {vfpu_ins, operand_a, operand_b, operand_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ins <= '0;
      core_a   <= '0;
      core_b   <= '0;
      core_c   <= '0;
      timer    <= '0;
      out_res  <= '0;
      out_ins  <= '0;
      out_err  <= 1'b0;
      stray    <= 1'b0;
    end else begin
      if (pop) {core_ins, core_a, core_b, core_c} <= mem[rd_ptr];
      if (state == ISSUE)                  timer <= '0;
      else if (state == WAIT && !res_rdy)  timer <= timer + TW'(1);
      // A result arriving on the timeout cycle takes priority over the error.
      if (finish) begin
        out_ins <= core_ins;
        out_res <= res_rdy ? res : '0;
        out_err <= !res_rdy;
      end
      if (res_rdy && state != WAIT) stray <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vfpu_op_sched.sv
// tb/tb_vfpu_op_sched.sv - randomized self-checking bench with a transaction-level reference model
module tb_vfpu_op_sched;
  localparam int DATA_W  = 32;
  localparam int INS_W   = 6;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int OCC_W   = $clog2(DEPTH) + 1;
  localparam int NEVER   = 100000;

  logic clk = 1'b0, rst_n = 1'b1, op_vld = 1'b0, op_rdy, core_vld;
  logic res_rdy = 1'b0, out_vld, out_rdy = 1'b1, out_err, stray;
  logic [INS_W-1:0]  vfpu_ins = '0, core_ins, out_ins;
  logic [DATA_W-1:0] operand_a = '0, operand_b = '0, operand_c = '0;
  logic [DATA_W-1:0] core_a, core_b, core_c, res = '0, out_res;
  logic [OCC_W-1:0]  occupancy;

  always #5 clk = ~clk;

  vfpu_op_sched #(.DATA_W(DATA_W), .INS_W(INS_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .op_rdy(op_rdy), .vfpu_ins(vfpu_ins),
    .operand_a(operand_a), .operand_b(operand_b), .operand_c(operand_c),
    .core_vld(core_vld), .core_ins(core_ins), .core_a(core_a), .core_b(core_b), .core_c(core_c),
    .res_rdy(res_rdy), .res(res), .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res),
    .out_ins(out_ins), .out_err(out_err), .occupancy(occupancy), .stray(stray)
  );

  typedef struct {
    logic [INS_W-1:0]  ins;
    logic [DATA_W-1:0] a, b, c;
  } op_t;

  op_t               mq[$];
  int                ord_q[$];
  bit                m_busy, m_done, m_stray, rec_order, stray_req, res_rand;
  int                m_issue, m_lat, cyc, lat_mode, n_tests, n_fail;
  logic [INS_W-1:0]  e_core_ins, e_out_ins;
  logic [DATA_W-1:0] e_core_a, e_core_b, e_core_c, e_out_res, res_pat;
  bit                e_out_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_waiting();
    return m_busy && !m_done && (cyc > m_issue);
  endfunction

  function automatic int pick_lat();
    case (lat_mode)
      0:       return NEVER;
      -1:      return int'($urandom_range(1, 20));
      -2:      return ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, 20));
      default: return lat_mode;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_done = 0; m_stray = 0; cyc = 0;
    e_core_ins = '0; e_core_a = '0; e_core_b = '0; e_core_c = '0;
    e_out_ins = '0; e_out_res = '0; e_out_err = 0;
  endtask

  // One clock: drive responder, check at negedge, advance the model at posedge.
  task automatic cycle();
    bit acc, wt;
    op_t o;
    wt = m_waiting();
    if (wt && (cyc - m_issue == m_lat)) begin
      res_rdy = 1'b1; res = res_rand ? DATA_W'($urandom) : res_pat;
    end else if (stray_req && !wt) begin
      res_rdy = 1'b1; res = DATA_W'($urandom);
    end else begin
      res_rdy = 1'b0; res = '0;
    end
    @(negedge clk);
    chk("op_rdy", op_rdy, mq.size() < DEPTH);
    chk("occupancy", occupancy, mq.size());
    chk("core_vld", core_vld, m_busy && cyc == m_issue);
    chk("core_ins", core_ins, e_core_ins);
    chk("core_a", core_a, e_core_a);
    chk("core_b", core_b, e_core_b);
    chk("core_c", core_c, e_core_c);
    chk("out_vld", out_vld, m_done);
    chk("out_res", out_res, e_out_res);
    chk("out_ins", out_ins, e_out_ins);
    chk("out_err", out_err, e_out_err);
    chk("stray", stray, m_stray);
    if (rec_order && out_vld && out_rdy) ord_q.push_back(int'(out_ins));
    @(posedge clk);
    acc = op_vld && (mq.size() < DEPTH);
    if (res_rdy && !wt) m_stray = 1;
    if (m_done) begin
      if (out_rdy) begin m_busy = 0; m_done = 0; end
    end else if (wt) begin
      if (res_rdy) begin
        m_done = 1; e_out_res = res; e_out_err = 0; e_out_ins = e_core_ins;
      end else if (cyc - m_issue == TIMEOUT) begin
        m_done = 1; e_out_res = '0; e_out_err = 1; e_out_ins = e_core_ins;
      end
    end else if (!m_busy && mq.size() > 0) begin
      o = mq.pop_front();
      m_busy = 1; m_issue = cyc + 1; m_lat = pick_lat();
      e_core_ins = o.ins; e_core_a = o.a; e_core_b = o.b; e_core_c = o.c;
    end
    if (acc) mq.push_back('{vfpu_ins, operand_a, operand_b, operand_c});
    cyc++;
    #1;
  endtask

  task automatic push(input logic [INS_W-1:0] ins, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c);
    bit acc;
    acc = 0;
    op_vld = 1'b1; vfpu_ins = ins; operand_a = a; operand_b = b; operand_c = c;
    for (int k = 0; k < 400 && !acc; k++) begin
      acc = (mq.size() < DEPTH);
      cycle();
    end
    op_vld = 1'b0;
    if (!acc) chk("push_bound", 0, 1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && (m_busy || mq.size() > 0); k++) cycle();
    if (m_busy || mq.size() > 0) chk("idle_bound", 0, 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && !m_done; k++) cycle();
    if (!m_done) chk("done_bound", 0, 1);
  endtask

  task automatic do_reset();
    op_vld = 1'b0; res_rdy = 1'b0; res = '0; stray_req = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_op_rdy", op_rdy, 1);
    chk("rst_core_vld", core_vld, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_stray", stray, 0);
    chk("rst_core_ins", core_ins, 0);
    chk("rst_core_abc", core_a | core_b | core_c, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_ins", out_ins, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; rec_order = 0; res_rand = 1; res_pat = '0; lat_mode = 3;
    model_reset();
    #2 do_reset();

    // single op with a fixed three-cycle core latency
    res_rand = 0; res_pat = 32'h4040_0000; lat_mode = 3;
    push(6'h01, 32'h3F80_0000, 32'h4000_0000, 32'h0);
    wait_done();
    chk("single_res", out_res, 32'h4040_0000);
    chk("single_ins", out_ins, 6'h01);
    chk("single_err", out_err, 0);
    chk("single_lat", cyc - m_issue, 4);
    wait_idle();
    res_rand = 1;

    // fill with a silent core: 5 ops, first one in flight, 4 held
    lat_mode = 0;
    for (int i = 0; i < 5; i++)
      push(INS_W'(i + 8), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
    chk("fill_occ", occupancy, DEPTH);
    chk("fill_rdy", op_rdy, 0);
    wait_done();
    chk("timeout_err", out_err, 1);
    chk("timeout_res", out_res, 0);
    chk("timeout_lat", cyc - (m_issue + 1), TIMEOUT);
    wait_idle();

    // result on the final WAIT cycle beats the timeout
    lat_mode = TIMEOUT;
    push(6'h2A, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
    wait_done();
    chk("late_res_err", out_err, 0);
    wait_idle();

    // backpressure in DONE while the FIFO keeps accepting
    lat_mode = 2; out_rdy = 1'b0;
    push(6'h11, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
    wait_done();
    push(6'h12, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
    push(6'h13, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
    run(10);
    chk("bp_out_vld", out_vld, 1);
    chk("bp_out_ins", out_ins, 6'h11);
    chk("bp_occ", occupancy, 2);
    out_rdy = 1'b1;
    wait_idle();

    // ordering under random core latency
    lat_mode = -1; rec_order = 1; ord_q.delete();
    for (int i = 1; i <= 4; i++)
      push(INS_W'(i), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
    wait_idle();
    rec_order = 0;
    chk("order_cnt", ord_q.size(), 4);
    for (int i = 0; i < ord_q.size(); i++) chk("order_ins", ord_q[i], i + 1);

    // random traffic: pushes, backpressure, timeouts and stray results
    lat_mode = -2;
    for (int k = 0; k < 800; k++) begin
      op_vld = 1'($urandom); vfpu_ins = INS_W'($urandom);
      operand_a = DATA_W'($urandom); operand_b = DATA_W'($urandom); operand_c = DATA_W'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      stray_req = ($urandom_range(0, 30) == 0);
      cycle();
    end
    op_vld = 1'b0; stray_req = 0; out_rdy = 1'b1;
    wait_idle();

    // stray result while idle after reset
    do_reset();
    stray_req = 1; cycle(); stray_req = 0; cycle();
    chk("stray_idle", stray, 1);

    // asynchronous reset mid-WAIT with three entries queued
    lat_mode = 0;
    for (int i = 0; i < 4; i++)
      push(INS_W'(i + 20), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
    run(3);
    chk("pre_rst_occ", occupancy, 3);
    do_reset();
    run(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end
endmodule
